// File: rtl/run_supervisor.sv
// Run controller for the processor Wrapper: holds it in reset, runs it, and
// ends the run on halt, bus stall or timeout while collecting activity stats.
//
// state | meaning
// IDLE  | waiting for start, Wrapper held in reset
// HOLD  | counting down the reset hold, Wrapper still in reset
// RUN   | Wrapper released, counting cycles and bus activity
// DONE  | run ended, statistics frozen until the next start
module run_supervisor #(
  parameter int CH_COUNT       = 4,
  parameter int CH_WIDTH       = 16,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int IDLE_CYCLES    = 256,
  parameter int CNT_W          = 32,
  localparam int CH_IDX_W      = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         halt_i,
  input  logic [CH_COUNT*CH_WIDTH-1:0] watch_i,
  output logic                         dut_reset_o,
  output logic                         running_o,
  output logic                         done_o,
  output logic [1:0]                   reason_o,
  output logic [CNT_W-1:0]             cycle_count_o,
  output logic [CNT_W-1:0]             change_count_o,
  output logic [CH_IDX_W-1:0]          last_change_ch_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] R_NONE    = 2'd0;
  localparam logic [1:0] R_HALT    = 2'd1;
  localparam logic [1:0] R_STALL   = 2'd2;
  localparam logic [1:0] R_TIMEOUT = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST    = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             hold_q, hold_d;
  logic [CNT_W-1:0]             idle_q, idle_d;
  logic [CNT_W-1:0]             cyc_q, cyc_d;
  logic [CNT_W-1:0]             chg_cnt_q, chg_cnt_d;
  logic [1:0]                   reason_q, reason_d;
  logic [CH_IDX_W-1:0]          last_q, last_d;
  logic [CH_COUNT*CH_WIDTH-1:0] prev_q, prev_d;
  logic                         dut_reset_d, running_d, done_d;

  logic [CH_COUNT-1:0]          chg;
  logic                         any_chg;
  logic [CH_IDX_W-1:0]          low_idx;

  // Scanning from the top down leaves the lowest changed channel in low_idx.
  always_comb begin
    chg     = '0;
    low_idx = '0;
    for (int k = CH_COUNT - 1; k >= 0; k--) begin
      chg[k] = (watch_i[k*CH_WIDTH +: CH_WIDTH] != prev_q[k*CH_WIDTH +: CH_WIDTH]);
      if (chg[k]) begin
        low_idx = CH_IDX_W'(k);
      end
    end
    any_chg = |chg;
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idle_d    = idle_q;
    cyc_d     = cyc_q;
    chg_cnt_d = chg_cnt_q;
    reason_d  = reason_q;
    last_d    = last_q;
    prev_d    = prev_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cyc_d     = '0;
          chg_cnt_d = '0;
          idle_d    = '0;
          reason_d  = R_NONE;
          last_d    = '0;
          hold_d    = HOLD_LOAD;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          prev_d  = watch_i;
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_RUN: begin
        cyc_d  = cyc_q + 1'b1;
        prev_d = watch_i;
        if (any_chg) begin
          if (chg_cnt_q != '1) begin
            chg_cnt_d = chg_cnt_q + 1'b1;
          end
          idle_d = '0;
          last_d = low_idx;
        end else begin
          idle_d = idle_q + 1'b1;
        end
        // End conditions use this cycle's pre-update counter values.
        if (halt_i) begin
          reason_d = R_HALT;
          state_d  = S_DONE;
        end else if (!any_chg && (idle_q == IDLE_LAST)) begin
          reason_d = R_STALL;
          state_d  = S_DONE;
        end else if (cyc_q == TIMEOUT_LAST) begin
          reason_d = R_TIMEOUT;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    dut_reset_d = (state_d == S_IDLE) || (state_d == S_HOLD);
    running_d   = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      idle_q      <= '0;
      cyc_q       <= '0;
      chg_cnt_q   <= '0;
      reason_q    <= R_NONE;
      last_q      <= '0;
      prev_q      <= '0;
      dut_reset_o <= 1'b1;
      running_o   <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      idle_q      <= idle_d;
      cyc_q       <= cyc_d;
      chg_cnt_q   <= chg_cnt_d;
      reason_q    <= reason_d;
      last_q      <= last_d;
      prev_q      <= prev_d;
      dut_reset_o <= dut_reset_d;
      running_o   <= running_d;
      done_o      <= done_d;
    end
  end

  assign reason_o         = reason_q;
  assign cycle_count_o    = cyc_q;
  assign change_count_o   = chg_cnt_q;
  assign last_change_ch_o = last_q;

endmodule

// File: tb/tb_run_supervisor.sv
// Bench for run_supervisor: directed scenarios plus randomized runs checked
// against a per-run reference model built from the run rules.
module tb_run_supervisor;

  localparam int CHN  = 2;
  localparam int CW   = 4;
  localparam int RC   = 4;
  localparam int TO   = 100;
  localparam int IDL  = 8;
  localparam int MAXJ = RC + TO + 2;

  logic             clock;
  logic             reset;
  logic             start;
  logic             halt_i;
  logic [CHN*CW-1:0] watch_i;
  logic             dut_reset_o;
  logic             running_o;
  logic             done_o;
  logic [1:0]       reason_o;
  logic [31:0]      cycle_count_o;
  logic [31:0]      change_count_o;
  logic [0:0]       last_change_ch_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [CHN*CW-1:0] wv [0:MAXJ];
  bit                hv [0:MAXJ];

  int exp_reason, exp_cycles, exp_chg, exp_last;
  int obs_hold, obs_done_edge;
  bit obs_clear, obs_run_at_done;

  run_supervisor #(
    .CH_COUNT(CHN), .CH_WIDTH(CW), .RESET_CYCLES(RC),
    .TIMEOUT_CYCLES(TO), .IDLE_CYCLES(IDL), .CNT_W(32)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .halt_i(halt_i),
    .watch_i(watch_i), .dut_reset_o(dut_reset_o), .running_o(running_o),
    .done_o(done_o), .reason_o(reason_o), .cycle_count_o(cycle_count_o),
    .change_count_o(change_count_o), .last_change_ch_o(last_change_ch_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Stimulus per edge j after the start edge: j=1..RC are hold edges (the
  // snapshot is taken at j=RC), RUN cycle i happens at edge RC+i.
  // mode 0: ch0 increments, 1: constant, 2: ch1 changes once at RUN edge 4,
  // 3: both channels toggle every edge, 4: random activity and random halt.
  task automatic build(input int mode, input int halt_at, input logic [7:0] base);
    logic [7:0] v;
    logic [7:0] jj;
    v = base;
    for (int j = 0; j <= MAXJ; j++) begin
      jj = 8'(j);
      case (mode)
        0: v = {base[7:4], base[3:0] + jj[3:0]};
        1: v = base;
        2: v = (j < RC + 4) ? base : (base ^ 8'hF0);
        3: v = jj[0] ? base : ~base;
        default: begin
          if ($urandom_range(0, 5) == 0) v[3:0] = v[3:0] ^ 4'($urandom_range(1, 15));
          if ($urandom_range(0, 5) == 0) v[7:4] = v[7:4] ^ 4'($urandom_range(1, 15));
        end
      endcase
      wv[j] = v;
      hv[j] = (mode == 4 && j <= RC) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (halt_at > 0 && RC + halt_at <= MAXJ) hv[RC + halt_at] = 1'b1;
  endtask

  // Reference: walk the RUN cycles, comparing each sampled bus to the previous one.
  task automatic model();
    logic [CHN*CW-1:0] p, w;
    int last_chg_cycle;
    bit any;
    int lk;
    bit ended;
    p = wv[RC];
    last_chg_cycle = 0;
    exp_chg = 0; exp_last = 0; exp_reason = 0; exp_cycles = 0;
    ended = 1'b0;
    for (int i = 1; i <= TO && !ended; i++) begin
      w = wv[RC + i];
      any = 1'b0; lk = 0;
      for (int k = CHN - 1; k >= 0; k--)
        if (w[k*CW +: CW] != p[k*CW +: CW]) begin any = 1'b1; lk = k; end
      p = w;
      if (any) begin exp_chg++; exp_last = lk; last_chg_cycle = i; end
      if (hv[RC + i]) begin exp_reason = 1; ended = 1'b1; end
      else if (!any && (i - last_chg_cycle) == IDL) begin exp_reason = 2; ended = 1'b1; end
      else if (i == TO) begin exp_reason = 3; ended = 1'b1; end
      exp_cycles = i;
    end
  endtask

  // Starts a run from IDLE or DONE and follows it until done_o or the bound.
  task automatic do_run();
    watch_i = wv[0];
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    obs_clear = (cycle_count_o == 0) && (change_count_o == 0) && (reason_o == 0) && !done_o;
    obs_hold = dut_reset_o ? 1 : 0;
    obs_done_edge = -1;
    obs_run_at_done = 1'b1;
    for (int j = 1; j <= MAXJ; j++) begin
      watch_i = wv[j];
      halt_i  = hv[j];
      start   = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      if (dut_reset_o) obs_hold++;
      if (done_o) begin
        obs_done_edge = j;
        obs_run_at_done = running_o;
        break;
      end
    end
    start = 1'b0;
    halt_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; halt_i = 1'b1; watch_i = 8'hA5;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (dut_reset_o !== 1'b1) $display("FAIL reset_dut_reset got %0b want 1", dut_reset_o); else n_pass++;
    n_checks++; if (running_o !== 1'b0) $display("FAIL reset_running got %0b want 0", running_o); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done got %0b want 0", done_o); else n_pass++;
    n_checks++; if (reason_o !== 2'd0) $display("FAIL reset_reason got %0d want 0", reason_o); else n_pass++;
    n_checks++; if (cycle_count_o !== 32'd0) $display("FAIL reset_cycles got %0d want 0", cycle_count_o); else n_pass++;
    n_checks++; if (change_count_o !== 32'd0) $display("FAIL reset_changes got %0d want 0", change_count_o); else n_pass++;
    n_checks++; if (last_change_ch_o !== 1'b0) $display("FAIL reset_last_ch got %0d want 0", last_change_ch_o); else n_pass++;
    start = 1'b0; halt_i = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (dut_reset_o !== 1'b1 || running_o !== 1'b0) $display("FAIL idle_after_reset got dut_reset=%0b running=%0b want 1 0", dut_reset_o, running_o); else n_pass++;
  endtask

  task automatic test_halt();
    build(0, 21, 8'h30);
    do_run();
    n_checks++; if (obs_hold !== RC) $display("FAIL halt_hold_len got %0d want %0d", obs_hold, RC); else n_pass++;
    n_checks++; if (reason_o !== 2'd1) $display("FAIL halt_reason got %0d want 1", reason_o); else n_pass++;
    n_checks++; if (cycle_count_o !== 32'd21) $display("FAIL halt_cycles got %0d want 21", cycle_count_o); else n_pass++;
    n_checks++; if (change_count_o !== 32'd21) $display("FAIL halt_changes got %0d want 21", change_count_o); else n_pass++;
    n_checks++; if (last_change_ch_o !== 1'b0) $display("FAIL halt_last_ch got %0d want 0", last_change_ch_o); else n_pass++;
    n_checks++; if (obs_done_edge !== RC + 21) $display("FAIL halt_done_edge got %0d want %0d", obs_done_edge, RC + 21); else n_pass++;
    n_checks++; if (obs_run_at_done !== 1'b0 || dut_reset_o !== 1'b0) $display("FAIL halt_done_outputs got running=%0b dut_reset=%0b want 0 0", obs_run_at_done, dut_reset_o); else n_pass++;
  endtask

  task automatic test_stall();
    build(1, 0, 8'h5C);
    do_run();
    n_checks++; if (reason_o !== 2'd2) $display("FAIL stall_const_reason got %0d want 2", reason_o); else n_pass++;
    n_checks++; if (cycle_count_o !== 32'd8) $display("FAIL stall_const_cycles got %0d want 8", cycle_count_o); else n_pass++;
    n_checks++; if (change_count_o !== 32'd0) $display("FAIL stall_const_changes got %0d want 0", change_count_o); else n_pass++;
    build(2, 0, 8'h17);
    do_run();
    n_checks++; if (obs_clear !== 1'b1) $display("FAIL stall_restart_clear got %0b want 1", obs_clear); else n_pass++;
    n_checks++; if (reason_o !== 2'd2) $display("FAIL stall_once_reason got %0d want 2", reason_o); else n_pass++;
    n_checks++; if (cycle_count_o !== 32'd12) $display("FAIL stall_once_cycles got %0d want 12", cycle_count_o); else n_pass++;
    n_checks++; if (last_change_ch_o !== 1'b1) $display("FAIL stall_once_last_ch got %0d want 1", last_change_ch_o); else n_pass++;
    n_checks++; if (change_count_o !== 32'd1) $display("FAIL stall_once_changes got %0d want 1", change_count_o); else n_pass++;
  endtask

  task automatic test_timeout();
    build(3, 0, 8'h69);
    do_run();
    n_checks++; if (reason_o !== 2'd3) $display("FAIL timeout_reason got %0d want 3", reason_o); else n_pass++;
    n_checks++; if (cycle_count_o !== 32'd100) $display("FAIL timeout_cycles got %0d want 100", cycle_count_o); else n_pass++;
    n_checks++; if (change_count_o !== 32'd100) $display("FAIL timeout_changes got %0d want 100", change_count_o); else n_pass++;
    n_checks++; if (last_change_ch_o !== 1'b0) $display("FAIL timeout_last_ch got %0d want 0", last_change_ch_o); else n_pass++;
    build(3, 100, 8'h0F);
    do_run();
    n_checks++; if (reason_o !== 2'd1) $display("FAIL halt_vs_timeout_reason got %0d want 1", reason_o); else n_pass++;
    n_checks++; if (cycle_count_o !== 32'd100) $display("FAIL halt_vs_timeout_cycles got %0d want 100", cycle_count_o); else n_pass++;
  endtask

  task automatic test_reset_restart();
    build(3, 0, 8'h3C);
    watch_i = wv[0];
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int j = 1; j <= RC + 10; j++) begin
      watch_i = wv[j];
      @(posedge clock); #1;
    end
    n_checks++; if (running_o !== 1'b1 || cycle_count_o !== 32'd10) $display("FAIL midrun_state got running=%0b cycles=%0d want 1 10", running_o, cycle_count_o); else n_pass++;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    n_checks++; if (dut_reset_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0) $display("FAIL midrun_reset_outputs got dut_reset=%0b running=%0b done=%0b want 1 0 0", dut_reset_o, running_o, done_o); else n_pass++;
    n_checks++; if (cycle_count_o !== 32'd0 || change_count_o !== 32'd0) $display("FAIL midrun_reset_counts got %0d %0d want 0 0", cycle_count_o, change_count_o); else n_pass++;
    build(1, 0, 8'hC3);
    do_run();
    n_checks++; if (reason_o !== 2'd2 || cycle_count_o !== 32'd8) $display("FAIL after_reset_run got reason=%0d cycles=%0d want 2 8", reason_o, cycle_count_o); else n_pass++;
    build(0, 5, 8'h00);
    do_run();
    n_checks++; if (obs_clear !== 1'b1) $display("FAIL restart_clear got %0b want 1", obs_clear); else n_pass++;
    n_checks++; if (obs_hold !== RC) $display("FAIL restart_hold_len got %0d want %0d", obs_hold, RC); else n_pass++;
    n_checks++; if (reason_o !== 2'd1 || cycle_count_o !== 32'd5 || change_count_o !== 32'd5) $display("FAIL restart_run got reason=%0d cycles=%0d changes=%0d want 1 5 5", reason_o, cycle_count_o, change_count_o); else n_pass++;
  endtask

  task automatic test_random();
    int ha;
    for (int r = 0; r < 10; r++) begin
      ha = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 120)) : 0;
      build(4, ha, 8'($urandom));
      model();
      do_run();
      n_checks++; if (reason_o !== 2'(exp_reason)) $display("FAIL rand%0d_reason got %0d want %0d", r, reason_o, exp_reason); else n_pass++;
      n_checks++; if (cycle_count_o !== 32'(exp_cycles)) $display("FAIL rand%0d_cycles got %0d want %0d", r, cycle_count_o, exp_cycles); else n_pass++;
      n_checks++; if (change_count_o !== 32'(exp_chg)) $display("FAIL rand%0d_changes got %0d want %0d", r, change_count_o, exp_chg); else n_pass++;
      n_checks++; if (last_change_ch_o !== 1'(exp_last)) $display("FAIL rand%0d_last_ch got %0d want %0d", r, last_change_ch_o, exp_last); else n_pass++;
      n_checks++; if (obs_done_edge !== RC + exp_cycles) $display("FAIL rand%0d_done_edge got %0d want %0d", r, obs_done_edge, RC + exp_cycles); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; halt_i = 1'b0; watch_i = '0;
    test_reset();
    test_halt();
    test_stall();
    test_timeout();
    test_reset_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
